// File: rtl/tx_word_framer.sv
// -----------------------------------------------------------------------------
// tx_word_framer
//
// Slices 32-bit upstream words onto an 8/16/32-bit PHY data bus, fills the bus
// with logical idle when there is nothing to send, and periodically inserts a
// SKP ordered set (COM + 3 x SKP) at word boundaries.
//
// A word is accepted on a PCLK edge where in_valid && in_ready. Its first slice
// is on MAC_TX_Data during the following cycle. Later slices follow on
// consecutive cycles. A new word may be accepted while the last slice of the
// previous word is on the bus, so back-to-back words have no gap.
//
// Ports
//   PCLK          in   parallel clock, rising edge
//   Reset_n       in   asynchronous active-low reset
//   tx_enable     in   transmit enable
//   DataBusWidth  in   6   output width 8/16/32, other values treated as 8
//   in_data       in   32  upstream word, byte 0 (bits 7:0) sent first
//   in_datak      in   4   per-byte K flags, bit i qualifies byte i
//   in_valid      in   upstream word valid
//   in_ready      out  framer accepts a word this cycle
//   MAC_TX_Data   out  32  symbols to PHY, bits above active width are 0
//   MAC_TX_DataK  out  4   K flags to PHY, bits above active width are 0
//   MAC_Data_En   out  output word valid
//   skp_sent      out  pulse on the last cycle of each SKP ordered set
// -----------------------------------------------------------------------------
module tx_word_framer #(
  parameter int unsigned SKP_INTERVAL = 1180  // legal 8..65535
) (
  input  logic        PCLK,
  input  logic        Reset_n,
  input  logic        tx_enable,
  input  logic [5:0]  DataBusWidth,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] MAC_TX_Data,
  output logic [3:0]  MAC_TX_DataK,
  output logic        MAC_Data_En,
  output logic        skp_sent
);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_DATA, ST_SKP} state_t;
  typedef enum logic [1:0] {W8, W16, W32} width_t;

  typedef struct packed {
    logic [3:0]  k;
    logic [31:0] data;
  } sym_t;

  localparam logic [15:0] CNT_LAST = 16'(SKP_INTERVAL - 1);
  // COM (0xBC) in byte 0, three SKP (0x1C) symbols above it, all K symbols.
  localparam logic [31:0] SKP_SYMS = 32'h1C1C_1CBC;
  localparam logic [3:0]  SKP_K    = 4'b1111;

  function automatic width_t decode_width(input logic [5:0] w);
    case (w)
      6'd16:   decode_width = W16;
      6'd32:   decode_width = W32;
      default: decode_width = W8;
    endcase
  endfunction

  // Index of the last slice of a word: N-1.
  function automatic logic [1:0] last_slice(input width_t w);
    case (w)
      W8:      last_slice = 2'd3;
      W16:     last_slice = 2'd1;
      default: last_slice = 2'd0;
    endcase
  endfunction

  // Slice idx of a word at width w, zero-extended to the full bus.
  function automatic sym_t pick_slice(input logic [31:0] d, input logic [3:0] k,
                                      input logic [1:0] idx, input width_t w);
    sym_t s;
    s = '0;
    case (w)
      W8: begin
        s.data[7:0] = d[{idx, 3'b000} +: 8];
        s.k[0]      = k[idx];
      end
      W16: begin
        s.data[15:0] = d[{idx[0], 4'b0000} +: 16];
        s.k[1:0]     = k[{idx[0], 1'b0} +: 2];
      end
      default: begin
        s.data = d;
        s.k    = k;
      end
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  slice_q, slice_d;
  width_t      width_q, eff_w;
  logic [1:0]  last_idx;
  logic        at_last, boundary, ready_c, accept;
  logic        skp_pending_q, skp_req, enter_skp;
  logic [15:0] cnt_q;
  logic [31:0] word_q;
  logic [3:0]  wordk_q;
  sym_t        sym_d;
  logic        en_d, sent_d;

  // While OFF/IDLE the width register follows the input every cycle, so a
  // word (or SKP) started from IDLE must be sliced with the live width, the
  // same value width_q picks up on that edge. Inside a word the latched value
  // holds.
  assign eff_w    = (state_q == ST_OFF || state_q == ST_IDLE)
                    ? decode_width(DataBusWidth) : width_q;
  assign last_idx = last_slice(eff_w);
  assign at_last  = (slice_q == last_idx);
  assign boundary = (state_q == ST_IDLE) || (state_q == ST_DATA && at_last);
  assign ready_c  = tx_enable && !skp_pending_q && boundary;
  assign accept   = ready_c && in_valid;
  assign in_ready = ready_c;

  assign skp_req   = tx_enable && (state_q != ST_OFF) && (cnt_q == CNT_LAST);
  assign enter_skp = (state_d == ST_SKP) && (state_q != ST_SKP);

  // Next state. At a word boundary a waiting word wins over a SKP request;
  // in_ready is already low while a SKP is pending, so the two never collide.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    slice_d = slice_q;
    case (state_q)
      ST_OFF: begin
        if (tx_enable) state_d = ST_IDLE;
      end
      ST_IDLE, ST_DATA: begin
        if (state_q == ST_DATA && !at_last) begin
          slice_d = slice_q + 2'd1;
        end else if (accept) begin
          state_d = ST_DATA;
          slice_d = 2'd0;
        end else if (skp_pending_q) begin
          state_d = ST_SKP;
          slice_d = 2'd0;
        end else if (tx_enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_SKP: begin
        if (!at_last) slice_d = slice_q + 2'd1;
        else          state_d = tx_enable ? ST_IDLE : ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Output values for the state being entered; they are registered on the
  // same edge so the bus always shows what state_q describes.
  always_comb begin
    sym_d  = '0;
    en_d   = 1'b0;
    sent_d = 1'b0;
    case (state_d)
      ST_IDLE: en_d = 1'b1;
      ST_DATA: begin
        en_d  = 1'b1;
        sym_d = accept ? pick_slice(in_data, in_datak, slice_d, eff_w)
                       : pick_slice(word_q, wordk_q, slice_d, eff_w);
      end
      ST_SKP: begin
        en_d   = 1'b1;
        sym_d  = pick_slice(SKP_SYMS, SKP_K, slice_d, eff_w);
        sent_d = (slice_d == last_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_OFF;
      slice_q      <= 2'd0;
      width_q      <= W8;
      // NOTE: the word holding register is a handful of flops, not a memory,
      // so it is reset along with everything else for deterministic outputs.
      word_q       <= '0;
      wordk_q      <= '0;
      MAC_TX_Data  <= '0;
      MAC_TX_DataK <= '0;
      MAC_Data_En  <= 1'b0;
      skp_sent     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      slice_q      <= slice_d;
      if (state_q == ST_OFF || state_q == ST_IDLE) width_q <= decode_width(DataBusWidth);
      if (accept) begin
        word_q  <= in_data;
        wordk_q <= in_datak;
      end
      MAC_TX_Data  <= sym_d.data;
      MAC_TX_DataK <= sym_d.k;
      MAC_Data_En  <= en_d;
      skp_sent     <= sent_d;
    end
  end

  // SKP interval counter and single-entry request flag. A request arriving
  // while one is already pending is simply absorbed.
  always_ff @(posedge PCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q         <= '0;
      skp_pending_q <= 1'b0;
    end else begin
      if (state_d == ST_OFF) begin
        cnt_q <= '0;
      end else if (tx_enable && state_q != ST_OFF) begin
        cnt_q <= (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
      end
      if (enter_skp)    skp_pending_q <= 1'b0;
      else if (skp_req) skp_pending_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_word_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_word_framer
//
// Directed bench for tx_word_framer with SKP_INTERVAL = 16. A table of
// per-cycle vectors (inputs plus expected outputs for that cycle) covers
// reset, 32/8/16-bit slicing, illegal width, width change mid-word and
// tx_enable dropping mid-word. Hand-written sequences cover periodic SKP
// insertion at width 16 and reset asserted in the middle of a SKP.
// -----------------------------------------------------------------------------
module tb_tx_word_framer;

  logic        PCLK;
  logic        Reset_n;
  logic        tx_enable;
  logic [5:0]  DataBusWidth;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] MAC_TX_Data;
  logic [3:0]  MAC_TX_DataK;
  logic        MAC_Data_En;
  logic        skp_sent;

  int total = 0;
  int bad   = 0;

  tx_word_framer #(.SKP_INTERVAL(16)) dut (
    .PCLK         (PCLK),
    .Reset_n      (Reset_n),
    .tx_enable    (tx_enable),
    .DataBusWidth (DataBusWidth),
    .in_data      (in_data),
    .in_datak     (in_datak),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .MAC_TX_Data  (MAC_TX_Data),
    .MAC_TX_DataK (MAC_TX_DataK),
    .MAC_Data_En  (MAC_Data_En),
    .skp_sent     (skp_sent)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [5:0]  w;
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic        e_rdy;
    logic        e_en;
    logic        e_sent;
    logic [3:0]  e_k;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[$];

  // Observed bundle layout: {in_ready, MAC_Data_En, skp_sent, DataK, Data}
  function automatic logic [38:0] observed();
    return {in_ready, MAC_Data_En, skp_sent, MAC_TX_DataK, MAC_TX_Data};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rdy/en/sent/k/data=%h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [5:0] w,
                     input logic [31:0] d, input logic [3:0] k, input logic v,
                     input logic e_rdy, input logic e_en, input logic e_sent,
                     input logic [3:0] e_k, input logic [31:0] e_d);
    vec_t t;
    t.rst = rst; t.en = en; t.w = w; t.d = d; t.k = k; t.v = v;
    t.e_rdy = e_rdy; t.e_en = e_en; t.e_sent = e_sent; t.e_k = e_k; t.e_d = e_d;
    tbl.push_back(t);
  endtask

  function automatic logic [31:0] skp_word(input int n);
    return {8'hBB, 8'(n), 8'hAA, 8'(n)};
  endfunction

  logic [31:0] act_d    [0:40];
  logic [3:0]  act_k    [0:40];
  logic        act_rdy  [0:40];
  logic        act_en   [0:40];
  logic        act_sent [0:40];

  initial begin
    int widx;
    int sent_cnt;

    Reset_n = 1'b0; tx_enable = 1'b0; DataBusWidth = 6'd8;
    in_data = '0; in_datak = '0; in_valid = 1'b0;

    // Group A: reset state, width 32 single-cycle word.
    add(1,0,32,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,0,32,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,32,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,32,32'h44332211,4'h0,1, 1,1,0,4'h0,32'h0);
    add(0,1,32,32'h0,4'h0,0,      1,1,0,4'h0,32'h44332211);
    add(0,1,32,32'h0,4'h0,0,      1,1,0,4'h0,32'h0);
    // Group B: width 8, 4 slices, back-to-back second word.
    add(1,0,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    add(0,1,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    add(0,1,8,32'hBC0201FF,4'h8,1, 1,1,0,4'h0,32'h0);
    add(0,1,8,32'hDEADBEEF,4'h0,1, 0,1,0,4'h0,32'hFF);
    add(0,1,8,32'hDEADBEEF,4'h0,1, 0,1,0,4'h0,32'h01);
    add(0,1,8,32'hDEADBEEF,4'h0,1, 0,1,0,4'h0,32'h02);
    add(0,1,8,32'hDEADBEEF,4'h0,1, 1,1,0,4'h1,32'hBC);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'hEF);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'hBE);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'hAD);
    add(0,1,8,32'h0,4'h0,0,       1,1,0,4'h0,32'hDE);
    add(0,1,8,32'h0,4'h0,0,       1,1,0,4'h0,32'h0);
    // Group C: width 32 -> 8 during DATA; 8 only takes effect after IDLE.
    add(1,0,32,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,32,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,32,32'hA3A2A1A0,4'h0,1, 1,1,0,4'h0,32'h0);
    add(0,1,8,32'hB3B2B1B0,4'h0,1,  1,1,0,4'h0,32'hA3A2A1A0);
    add(0,1,8,32'h0,4'h0,0,       1,1,0,4'h0,32'hB3B2B1B0);
    add(0,1,8,32'hC3C2C1C0,4'h1,1, 1,1,0,4'h0,32'h0);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h1,32'hC0);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'hC1);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'hC2);
    add(0,1,8,32'h0,4'h0,0,       1,1,0,4'h0,32'hC3);
    add(0,1,8,32'h0,4'h0,0,       1,1,0,4'h0,32'h0);
    // Group D: tx_enable dropped while slice 1 of 4 is on the bus.
    add(1,0,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    add(0,1,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    add(0,1,8,32'h04030201,4'h2,1, 1,1,0,4'h0,32'h0);
    add(0,1,8,32'h0,4'h0,0,       0,1,0,4'h0,32'h01);
    add(0,0,8,32'h0,4'h0,0,       0,1,0,4'h1,32'h02);
    add(0,0,8,32'h99999999,4'h0,1, 0,1,0,4'h0,32'h03);
    add(0,0,8,32'h99999999,4'h0,1, 0,1,0,4'h0,32'h04);
    add(0,0,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    add(0,0,8,32'h0,4'h0,0,       0,0,0,4'h0,32'h0);
    // Group E: illegal width 20 behaves as 8, then width 16 from IDLE.
    add(1,0,20,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,20,32'h0,4'h0,0,      0,0,0,4'h0,32'h0);
    add(0,1,20,32'h55AA33CC,4'h4,1, 1,1,0,4'h0,32'h0);
    add(0,1,20,32'h0,4'h0,0,      0,1,0,4'h0,32'hCC);
    add(0,1,20,32'h0,4'h0,0,      0,1,0,4'h0,32'h33);
    add(0,1,20,32'h0,4'h0,0,      0,1,0,4'h1,32'hAA);
    add(0,1,20,32'h0,4'h0,0,      1,1,0,4'h0,32'h55);
    add(0,1,16,32'h0,4'h0,0,      1,1,0,4'h0,32'h0);
    add(0,1,16,32'h87654321,4'hC,1, 1,1,0,4'h0,32'h0);
    add(0,1,16,32'h0,4'h0,0,      0,1,0,4'h0,32'h4321);
    add(0,1,16,32'h0,4'h0,0,      1,1,0,4'h3,32'h8765);
    add(0,1,16,32'h0,4'h0,0,      1,1,0,4'h0,32'h0);

    @(posedge PCLK); #1;
    foreach (tbl[i]) begin
      Reset_n      = !tbl[i].rst;
      tx_enable    = tbl[i].en;
      DataBusWidth = tbl[i].w;
      in_data      = tbl[i].d;
      in_datak     = tbl[i].k;
      in_valid     = tbl[i].v;
      @(negedge PCLK);
      check($sformatf("vec%0d", i), observed(),
            {tbl[i].e_rdy, tbl[i].e_en, tbl[i].e_sent, tbl[i].e_k, tbl[i].e_d});
      if (tbl[i].rst) #1 Reset_n = 1'b1;
      @(posedge PCLK); #1;
    end

    // SKP insertion: width 16, in_valid held high. Cycle 0 is the reset
    // cycle; the framer enters IDLE at its closing edge.
    Reset_n = 1'b0; tx_enable = 1'b1; DataBusWidth = 6'd16;
    in_valid = 1'b1; in_datak = 4'h0; widx = 1; in_data = skp_word(widx);
    @(negedge PCLK);
    #1 Reset_n = 1'b1;
    sent_cnt = 0;
    for (int c = 1; c <= 35; c++) begin
      @(posedge PCLK); #1;
      if (act_rdy[c-1] === 1'b1 && c > 1) begin
        widx++;
        in_data = skp_word(widx);
      end
      @(negedge PCLK);
      act_d[c]    = MAC_TX_Data;
      act_k[c]    = MAC_TX_DataK;
      act_rdy[c]  = in_ready;
      act_en[c]   = MAC_Data_En;
      act_sent[c] = skp_sent;
      if (skp_sent === 1'b1) sent_cnt++;
    end

    check("skp_c16_lo",  {act_rdy[16], act_en[16], act_sent[16], act_k[16], act_d[16]}, {1'b0,1'b1,1'b0,4'h0,32'h0000AA08});
    check("skp_c17_hi",  {act_rdy[17], act_en[17], act_sent[17], act_k[17], act_d[17]}, {1'b0,1'b1,1'b0,4'h0,32'h0000BB08});
    check("skp_c18_com", {act_rdy[18], act_en[18], act_sent[18], act_k[18], act_d[18]}, {1'b0,1'b1,1'b0,4'h3,32'h00001CBC});
    check("skp_c19_skp", {act_rdy[19], act_en[19], act_sent[19], act_k[19], act_d[19]}, {1'b0,1'b1,1'b1,4'h3,32'h00001C1C});
    check("skp_c20_idle",{act_rdy[20], act_en[20], act_sent[20], act_k[20], act_d[20]}, {1'b1,1'b1,1'b0,4'h0,32'h0});
    check("skp_c21_lo",  {act_rdy[21], act_en[21], act_sent[21], act_k[21], act_d[21]}, {1'b0,1'b1,1'b0,4'h0,32'h0000AA09});
    check("skp_c32_acc", {act_rdy[32], act_en[32], act_sent[32], act_k[32], act_d[32]}, {1'b1,1'b1,1'b0,4'h0,32'h0000BB0E});
    check("skp_c33_lo",  {act_rdy[33], act_en[33], act_sent[33], act_k[33], act_d[33]}, {1'b0,1'b1,1'b0,4'h0,32'h0000AA0F});
    check("skp_c34_hi",  {act_rdy[34], act_en[34], act_sent[34], act_k[34], act_d[34]}, {1'b0,1'b1,1'b0,4'h0,32'h0000BB0F});
    check("skp_c35_com", {act_rdy[35], act_en[35], act_sent[35], act_k[35], act_d[35]}, {1'b0,1'b1,1'b0,4'h3,32'h00001CBC});
    check("skp_sent_count", 39'(sent_cnt), 39'd1);

    // Reset in the middle of the SKP: outputs clear at once, no resumption.
    #1 Reset_n = 1'b0;
    #1 check("rst_mid_skp", observed(), 39'h0);
    #1 Reset_n = 1'b1; tx_enable = 1'b0; in_valid = 1'b0;
    @(negedge PCLK);
    check("post_rst_off", observed(), 39'h0);
    @(posedge PCLK); #1 tx_enable = 1'b1;
    @(negedge PCLK);
    check("post_rst_enter", observed(), 39'h0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("post_rst_idle", observed(), {1'b1,1'b1,1'b0,4'h0,32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_word_framer.md
TX_WORD_FRAMER -- requirements
Module: tx_word_framer

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 1180, meaning PCLK cycles (while enabled) between SKP ordered-set requests; legal range 8..65535.
REQ-002 SHALL have port PCLK  input  1  parallel clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_enable  input  1  transmit enable.
REQ-005 SHALL have port DataBusWidth  input  6  output width in bits: 8, 16 or 32; any other value behaves as 8.
REQ-006 SHALL have port in_data  input  32  upstream word; byte0 = bits 7:0, sent first.
REQ-007 SHALL have port in_datak  input  4  per-byte K flag; bit i qualifies byte i.
REQ-008 SHALL have port in_valid  input  1  upstream word valid.
REQ-009 SHALL have port in_ready  output  1  framer accepts word this cycle.
REQ-010 SHALL have port MAC_TX_Data  output  32  symbols to PHY; bits above active width are 0.
REQ-011 SHALL have port MAC_TX_DataK  output  4  K flags to PHY; bits above active width are 0.
REQ-012 SHALL have port MAC_Data_En  output  1  output word valid.
REQ-013 SHALL have port skp_sent  output  1  one-cycle pulse on the last cycle of each SKP ordered set.

Function
REQ-014 SHALL implement states OFF, IDLE, DATA, SKP; all outputs registered.
REQ-015 SHALL define slices per word N = 4 (width 8), 2 (width 16), 1 (width 32).
REQ-016 SHALL latch DataBusWidth into width_q every cycle in OFF or IDLE only; changes during DATA or SKP take effect on return to IDLE.
REQ-017 OFF: MAC_Data_En=0, Data/DataK=0; go IDLE when tx_enable=1.
REQ-018 IDLE: drive logical idle, MAC_Data_En=1, Data=0, DataK=0.
REQ-019 SHALL drive in_ready=1 only when tx_enable=1, skp_pending=0, and state is IDLE or DATA on its last slice; in_ready is combinational from registered state.
REQ-020 Transfer when in_valid and in_ready at a PCLK edge; first slice appears on MAC_TX_Data the next cycle (latency 1).
REQ-021 DATA: emit slice k (k=0..N-1) as bytes [k*W/8 .. (k+1)*W/8-1] of the accepted word, with matching DataK bits, MAC_Data_En=1.
REQ-022 After the last slice: accept new word (stay DATA, back-to-back, no gap), else go SKP if skp_pending, else IDLE if tx_enable, else OFF.
REQ-023 SKP counter SHALL increment each cycle tx_enable=1 and state is not OFF; at SKP_INTERVAL-1 it wraps to 0 and sets skp_pending.
REQ-024 A request while skp_pending=1 SHALL be dropped (no queueing beyond one).
REQ-025 skp_pending SHALL be serviced only at a word boundary (IDLE, or DATA last slice); never split a data word.
REQ-026 SKP: emit 4 symbols COM 0xBC (K=1), SKP 0x1C, 0x1C, 0x1C (K=1) over N cycles in byte order; clear skp_pending on entry; skp_sent on last cycle.
REQ-027 After SKP: IDLE if tx_enable=1, else OFF; in_ready=0 throughout SKP.
REQ-028 tx_enable falling mid-word or mid-SKP SHALL complete the current word/ordered set before OFF; no new word accepted.
REQ-029 Simultaneous skp request and word acceptance at a boundary: the word is accepted; SKP sent at the next boundary.
REQ-030 Counter resets to 0 on entering OFF.

Reset
REQ-031 Reset_n low SHALL asynchronously force state OFF, counter 0, skp_pending 0, width_q 8, MAC_TX_Data 0, MAC_TX_DataK 0, MAC_Data_En 0, skp_sent 0, in_ready 0.
REQ-032 Reset mid-word or mid-SKP SHALL discard the partial word/ordered set; no resumption after release.
REQ-033 After release, first enabled cycle SHALL enter IDLE, with idle on MAC_TX_Data the following cycle.

Verification
REQ-034 Width 32, word 0x44332211 K=0000 -> next cycle Data=0x44332211, En=1, one cycle.
REQ-035 Width 8, word 0xBC0201FF K=1000 -> 4 cycles Data 0xFF,0x01,0x02,0xBC with DataK 0,0,0,1; in_ready=1 only on 4th cycle.
REQ-036 SKP_INTERVAL=16, width 16, continuous valid -> every ~16 cycles 2-cycle SKP: 0x1CBC K=0011, then 0x1C1C K=0011; skp_sent on the second; no word split.
REQ-037 Width changed 32->8 during DATA -> current word completes at 32; next word sliced at 8 only after IDLE.
REQ-038 tx_enable dropped on slice 1 of 4 -> slices 2,3 emitted, then En=0; Reset_n pulsed mid-SKP -> outputs 0 immediately.
